// File: rtl/score_combo_ctrl.sv
// Scoring stage: tracks combo / max combo and accumulates a 4-digit packed-BCD
// score with a combo-dependent multiplier. Each score addend is added one BCD
// digit per clock, and one further event can wait in a single pending slot.
module score_combo_ctrl #(
    parameter int PERF_PTS = 3,
    parameter int NORM_PTS = 1,
    parameter int COMBO_X2 = 10,
    parameter int COMBO_X3 = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic [1:0]  i_judge,
    output logic [15:0] o_score,
    output logic        o_score_valid,
    output logic [7:0]  o_combo,
    output logic [7:0]  o_max_combo,
    output logic        o_busy,
    output logic        o_drop
);

    localparam logic [3:0] PERF = 4'(PERF_PTS);
    localparam logic [3:0] NORM = 4'(NORM_PTS);
    localparam logic [7:0] X2   = 8'(COMBO_X2);
    localparam logic [7:0] X3   = 8'(COMBO_X3);

    typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] work;
    logic [3:0]  addend;
    logic        carry;
    logic        sat;
    logic        pend_valid;
    logic [3:0]  pend_addend;

    logic        hit;
    logic        miss;
    logic [7:0]  new_combo;
    logic [3:0]  base;
    logic [3:0]  hit_addend;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_in;
    logic [3:0]  add_in;
    logic [4:0]  sum;
    logic [3:0]  digit_out;
    logic        carry_out;

    logic        load_addend;
    logic        addend_from_pend;
    logic        write_pend;
    logic        clear_pend;
    logic        drop_evt;

    assign hit    = i_judge[1];
    assign miss   = (i_judge == 2'b01);
    assign o_busy = (state != IDLE);

    // Post-increment combo and the scaled single-digit addend for this hit
    always_comb begin
        new_combo = (o_combo == 8'hFF) ? 8'hFF : o_combo + 8'd1;
        base      = i_judge[0] ? PERF : NORM;
        if (new_combo >= X3) begin
            hit_addend = base + {base[2:0], 1'b0};
        end else if (new_combo >= X2) begin
            hit_addend = {base[2:0], 1'b0};
        end else begin
            hit_addend = base;
        end
    end

    // One BCD digit step: digit k of the working register plus addend or carry
    always_comb begin
        case (state)
            ADD1:    digit_sel = 2'd1;
            ADD2:    digit_sel = 2'd2;
            ADD3:    digit_sel = 2'd3;
            default: digit_sel = 2'd0;
        endcase
        digit_in = work[{digit_sel, 2'b00} +: 4];
        add_in   = (state == ADD0) ? addend : {3'b000, carry};
        sum      = {1'b0, digit_in} + {1'b0, add_in};
        if (sum >= 5'd10) begin
            digit_out = 4'(sum - 5'd10);
            carry_out = 1'b1;
        end else begin
            digit_out = sum[3:0];
            carry_out = 1'b0;
        end
    end

    // State register for the digit-serial adder
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and event routing: start, queue in pending, or drop.
    // An event arriving at COMMIT with nothing pending starts straight away,
    // since it would otherwise sit in pending while the adder returns to IDLE.
    always_comb begin
        state_next       = state;
        load_addend      = 1'b0;
        addend_from_pend = 1'b0;
        write_pend       = 1'b0;
        clear_pend       = 1'b0;
        drop_evt         = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next  = ADD0;
                    load_addend = 1'b1;
                end
            end
            ADD0, ADD1, ADD2, ADD3: begin
                case (state)
                    ADD0:    state_next = ADD1;
                    ADD1:    state_next = ADD2;
                    ADD2:    state_next = ADD3;
                    default: state_next = COMMIT;
                endcase
                if (hit) begin
                    if (!pend_valid) begin
                        write_pend = 1'b1;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (pend_valid) begin
                    state_next       = ADD0;
                    load_addend      = 1'b1;
                    addend_from_pend = 1'b1;
                    clear_pend       = 1'b1;
                    write_pend       = hit;
                end else if (hit) begin
                    state_next  = ADD0;
                    load_addend = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Combo tracking, pending slot, working register and score commit
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            o_score       <= 16'h0000;
            o_score_valid <= 1'b0;
            o_combo       <= 8'd0;
            o_max_combo   <= 8'd0;
            o_drop        <= 1'b0;
            work          <= 16'h0000;
            addend        <= 4'd0;
            carry         <= 1'b0;
            sat           <= 1'b0;
            pend_valid    <= 1'b0;
            pend_addend   <= 4'd0;
        end else begin
            o_score_valid <= 1'b0;
            o_drop        <= drop_evt;

            if (miss) begin
                o_combo <= 8'd0;
            end else if (hit) begin
                o_combo <= new_combo;
                if (new_combo > o_max_combo) begin
                    o_max_combo <= new_combo;
                end
            end

            if (load_addend) begin
                addend <= addend_from_pend ? pend_addend : hit_addend;
            end
            if (clear_pend) begin
                pend_valid <= 1'b0;
            end
            if (write_pend) begin
                pend_valid  <= 1'b1;
                pend_addend <= hit_addend;
            end

            case (state)
                ADD0, ADD1, ADD2, ADD3: begin
                    work[{digit_sel, 2'b00} +: 4] <= digit_out;
                    carry <= carry_out;
                    if (state == ADD3 && carry_out) begin
                        sat <= 1'b1;
                    end
                end
                COMMIT: begin
                    o_score       <= sat ? 16'h9999 : work;
                    work          <= sat ? 16'h9999 : work;
                    o_score_valid <= 1'b1;
                    sat           <= 1'b0;
                    carry         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_combo_ctrl.sv
// Testbench for score_combo_ctrl: directed scenarios plus a randomized run
// checked against an event-level model of combo, pending slot and score.
module tb_score_combo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_clear = 1'b0;
    logic [1:0]  i_judge = 2'b00;
    logic [15:0] o_score;
    logic        o_score_valid;
    logic [7:0]  o_combo;
    logic [7:0]  o_max_combo;
    logic        o_busy;
    logic        o_drop;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: decimal score, combo counts, countdown to the
    // next commit (-1 when the adder is idle) and the single pending slot.
    int mScore, mCombo, mMax, mLeft, mCur, mPendAdd;
    bit mPend, mValid, mDrop;

    score_combo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (i_clear),
        .i_judge      (i_judge),
        .o_score      (o_score),
        .o_score_valid(o_score_valid),
        .o_combo      (o_combo),
        .o_max_combo  (o_max_combo),
        .o_busy       (o_busy),
        .o_drop       (o_drop)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Advance the reference model by one clock edge
    task automatic modelEdge(input logic [1:0] judge, input logic clr);
        int add;
        bit hitEvt;
        mValid = 0;
        mDrop  = 0;
        if (clr) begin
            mScore = 0; mCombo = 0; mMax = 0; mLeft = -1;
            mCur = 0; mPend = 0; mPendAdd = 0;
        end else begin
            hitEvt = judge[1];
            add = 0;
            if (judge == 2'b01) begin
                mCombo = 0;
            end else if (hitEvt) begin
                if (mCombo < 255) mCombo++;
                if (mCombo > mMax) mMax = mCombo;
                add = ((judge == 2'b11) ? 3 : 1) * ((mCombo >= 30) ? 3 : ((mCombo >= 10) ? 2 : 1));
            end
            if (mLeft == 0) begin
                mScore = (mScore + mCur > 9999) ? 9999 : mScore + mCur;
                mValid = 1;
                if (mPend) begin
                    mCur = mPendAdd; mLeft = 4;
                    mPend = hitEvt; mPendAdd = add;
                end else if (hitEvt) begin
                    mCur = add; mLeft = 4;
                end else begin
                    mLeft = -1;
                end
            end else if (mLeft > 0) begin
                if (hitEvt) begin
                    if (!mPend) begin
                        mPend = 1; mPendAdd = add;
                    end else begin
                        mDrop = 1;
                    end
                end
                mLeft--;
            end else if (hitEvt) begin
                mCur = add; mLeft = 4;
            end
        end
    endtask

    // Drive one cycle of inputs, step past the edge, and advance the model
    task automatic applyStimulus(input logic [1:0] judge, input logic clr, input logic rs);
        i_judge = judge;
        i_clear = clr;
        rst     = rs;
        @(posedge clk);
        #1;
        modelEdge(judge, clr | rs);
        i_judge = 2'b00;
        i_clear = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b0, 1'b1);
        vectors++; if (o_score !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_score got %h exp 0000", o_score); end
        vectors++; if (o_combo !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_combo got %0d exp 0", o_combo); end
        vectors++; if (o_max_combo !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_max got %0d exp 0", o_max_combo); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", o_busy); end
        vectors++; if ({o_score_valid, o_drop} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_pulses got %b exp 00", {o_score_valid, o_drop}); end
    endtask

    task automatic test_single_perfect();
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        vectors++; if (o_combo !== 8'd1) begin miscompares++; $display("[TB] FAIL single_combo got %0d exp 1", o_combo); end
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy got %b exp 1", o_busy); end
        for (int k = 2; k <= 7; k++) begin
            applyStimulus(2'b00, 1'b0, 1'b0);
            vectors++;
            if (o_score_valid !== (k == 6)) begin
                miscompares++; $display("[TB] FAIL single_valid_n%0d got %b exp %b", k, o_score_valid, (k == 6));
            end
            if (k == 5) begin
                vectors++; if (o_score !== 16'h0000) begin miscompares++; $display("[TB] FAIL single_early_score got %h exp 0000", o_score); end
            end
            if (k == 6) begin
                vectors++; if (o_score !== 16'h0003) begin miscompares++; $display("[TB] FAIL single_score got %h exp 0003", o_score); end
                vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle got %b exp 0", o_busy); end
            end
        end
    endtask

    task automatic test_normal_combo();
        applyStimulus(2'b00, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(2'b10, 1'b0, 1'b0);
            idle(19);
            if (i == 9) begin
                vectors++; if (o_score !== 16'h0009) begin miscompares++; $display("[TB] FAIL normal9_score got %h exp 0009", o_score); end
            end
        end
        vectors++; if (o_score !== 16'h0011) begin miscompares++; $display("[TB] FAIL normal10_score got %h exp 0011", o_score); end
        vectors++; if (o_combo !== 8'd10) begin miscompares++; $display("[TB] FAIL normal10_combo got %0d exp 10", o_combo); end
        vectors++; if (o_max_combo !== 8'd10) begin miscompares++; $display("[TB] FAIL normal10_max got %0d exp 10", o_max_combo); end
    endtask

    task automatic test_back_to_back();
        int valids;
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b11, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b0);
        vectors++; if (o_drop !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_second_drop got %b exp 0", o_drop); end
        applyStimulus(2'b11, 1'b0, 1'b0);
        vectors++; if (o_drop !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_third_drop got %b exp 1", o_drop); end
        vectors++; if (o_combo !== 8'd3) begin miscompares++; $display("[TB] FAIL b2b_combo got %0d exp 3", o_combo); end
        applyStimulus(2'b00, 1'b0, 1'b0);
        vectors++; if (o_drop !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drop_width got %b exp 0", o_drop); end
        valids = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0);
            if (o_score_valid === 1'b1) valids++;
        end
        vectors++; if (valids != 2) begin miscompares++; $display("[TB] FAIL b2b_valid_count got %0d exp 2", valids); end
        vectors++; if (o_score !== 16'h0006) begin miscompares++; $display("[TB] FAIL b2b_score got %h exp 0006", o_score); end
    endtask

    task automatic test_miss();
        int valids;
        applyStimulus(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'b10, 1'b0, 1'b0);
            idle(9);
        end
        vectors++; if (o_score !== 16'h0015) begin miscompares++; $display("[TB] FAIL miss_pre_score got %h exp 0015", o_score); end
        applyStimulus(2'b01, 1'b0, 1'b0);
        vectors++; if (o_combo !== 8'd0) begin miscompares++; $display("[TB] FAIL miss_combo got %0d exp 0", o_combo); end
        vectors++; if (o_max_combo !== 8'd12) begin miscompares++; $display("[TB] FAIL miss_max got %0d exp 12", o_max_combo); end
        valids = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0);
            if (o_score_valid === 1'b1 || o_busy === 1'b1) valids++;
        end
        vectors++; if (valids != 0) begin miscompares++; $display("[TB] FAIL miss_activity got %0d exp 0", valids); end
        vectors++; if (o_score !== 16'h0015) begin miscompares++; $display("[TB] FAIL miss_score got %h exp 0015", o_score); end
    endtask

    task automatic test_clear_abort();
        int valids;
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b10, 1'b0, 1'b0);
        idle(2);
        applyStimulus(2'b11, 1'b1, 1'b0);
        vectors++;
        if ({o_score, o_combo, o_max_combo, o_busy, o_score_valid, o_drop} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_outputs got score=%h combo=%0d max=%0d busy=%b valid=%b drop=%b exp all 0",
                     o_score, o_combo, o_max_combo, o_busy, o_score_valid, o_drop);
        end
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0);
            if (o_score_valid === 1'b1) valids++;
        end
        vectors++; if (valids != 0) begin miscompares++; $display("[TB] FAIL clear_valid got %0d exp 0", valids); end
        vectors++; if (o_score !== 16'h0000) begin miscompares++; $display("[TB] FAIL clear_score got %h exp 0000", o_score); end
    endtask

    task automatic test_saturation();
        applyStimulus(2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 1200; i++) begin
            applyStimulus(2'b11, 1'b0, 1'b0);
            for (int j = 0; j < 9; j++) begin
                applyStimulus(2'b00, 1'b0, 1'b0);
                if (o_score_valid === 1'b1 && (i % 50 == 0 || i > 1100)) begin
                    vectors++;
                    if (o_score !== toBcd(mScore)) begin
                        miscompares++; $display("[TB] FAIL sat_progress ev%0d got %h exp %h", i, o_score, toBcd(mScore));
                    end
                end
            end
        end
        vectors++; if (o_score !== 16'h9999) begin miscompares++; $display("[TB] FAIL sat_score got %h exp 9999", o_score); end
        vectors++; if (o_combo !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_combo got %0d exp 255", o_combo); end
        vectors++; if (o_max_combo !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_max got %0d exp 255", o_max_combo); end
    endtask

    task automatic test_random();
        logic [1:0] j;
        logic c;
        int r;
        applyStimulus(2'b00, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r = int'($urandom_range(0, 199));
            if (r < 90) j = 2'b00;
            else if (r < 95) j = 2'b01;
            else if (r < 150) j = 2'b10;
            else j = 2'b11;
            c = ($urandom_range(0, 299) == 0);
            applyStimulus(j, c, 1'b0);
            vectors++;
            if (o_score !== toBcd(mScore) || o_score_valid !== mValid || o_combo !== 8'(mCombo) ||
                o_max_combo !== 8'(mMax) || o_busy !== (mLeft >= 0) || o_drop !== mDrop) begin
                miscompares++;
                $display("[TB] FAIL rand_c%0d got score=%h v=%b combo=%0d max=%0d busy=%b drop=%b exp score=%h v=%b combo=%0d max=%0d busy=%b drop=%b",
                         cyc, o_score, o_score_valid, o_combo, o_max_combo, o_busy, o_drop,
                         toBcd(mScore), mValid, mCombo, mMax, (mLeft >= 0), mDrop);
            end
        end
    endtask

    // Run every scenario in order and report
    initial begin
        test_reset();
        test_single_perfect();
        test_normal_combo();
        test_back_to_back();
        test_miss();
        test_clear_abort();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
